// File: rtl/mv_interp_filter.sv
// Linear-interpolating upsampler: each input sample yields 2^RATIO_LOG2 outputs stepping from the previous sample.
// Build option MV_INTERP_ROUND_EN selects round-half-up output scaling instead of floor.
module mv_interp_filter #(
  parameter int RATIO_LOG2 = 4,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy
);

  localparam int AW = DW + 1 + RATIO_LOG2;
  localparam logic [RATIO_LOG2-1:0] K_LAST = {RATIO_LOG2{1'b1}};
  localparam logic [RATIO_LOG2-1:0] K_ONE  = RATIO_LOG2'(1);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

`ifdef MV_INTERP_ROUND_EN
  localparam logic signed [AW-1:0] RND_BIAS = AW'(2 ** (RATIO_LOG2 - 1));

  // Scale the accumulator back to sample units, rounding half toward +inf.
  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] a);
    return (a + RND_BIAS) >>> RATIO_LOG2;
  endfunction
`else
  // Scale the accumulator back to sample units with floor semantics.
  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] a);
    return a >>> RATIO_LOG2;
  endfunction
`endif

  state_t                 state_r;
  logic [DW-1:0]          x_prev_r;
  logic [DW-1:0]          x_new_r;
  logic signed [DW:0]     delta_r;
  logic signed [AW-1:0]   acc_r;
  logic [RATIO_LOG2-1:0]  k_r;
  logic [DW-1:0]          dout_r;
  logic                   dout_valid_r;
  logic                   din_ready_r;
  logic                   busy_r;

  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic                   k_last_s;
  logic signed [DW:0]     delta_in_s;
  logic signed [AW-1:0]   acc_load_s;
  logic signed [AW-1:0]   acc_next_s;

  // Handshake decodes and the widened arithmetic feeding the accumulator.
  always_comb begin
    in_xfer_s  = din_valid & din_ready_r;
    out_xfer_s = dout_valid_r & dout_ready;
    k_last_s   = (k_r == K_LAST);
    delta_in_s = $signed({din[DW-1], din}) - $signed({x_prev_r[DW-1], x_prev_r});
    acc_load_s = $signed({x_prev_r[DW-1], x_prev_r, {RATIO_LOG2{1'b0}}});
    acc_next_s = acc_r + $signed({{RATIO_LOG2{delta_r[DW]}}, delta_r});
  end

  // Control FSM with the datapath registers and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= ST_PRIME;
      x_prev_r     <= '0;
      x_new_r      <= '0;
      delta_r      <= '0;
      acc_r        <= '0;
      k_r          <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      din_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_PRIME: begin
          if (in_xfer_s) begin
            x_prev_r <= din;
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_PRIME;
          end
        end
        ST_WAIT: begin
          if (in_xfer_s) begin
            delta_r      <= delta_in_s;
            acc_r        <= acc_load_s;
            x_new_r      <= din;
            k_r          <= '0;
            dout_r       <= DW'(scale(acc_load_s));
            dout_valid_r <= 1'b1;
            din_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_RUN;
          end else begin
            state_r      <= ST_WAIT;
          end
        end
        ST_RUN: begin
          // Everything holds while the downstream stalls.
          if (out_xfer_s) begin
            if (k_last_s) begin
              dout_valid_r <= 1'b0;
              x_prev_r     <= x_new_r;
              din_ready_r  <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= ST_WAIT;
            end else begin
              acc_r        <= acc_next_s;
              k_r          <= k_r + K_ONE;
              dout_r       <= DW'(scale(acc_next_s));
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r      <= ST_PRIME;
          dout_valid_r <= 1'b0;
          din_ready_r  <= 1'b1;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = din_ready_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_mv_interp_filter.sv
// Scoreboard bench for mv_interp_filter: a reference model queues expected outputs per accepted input,
// a monitor compares every presented sample plus the handshake/busy flags.
module tb_mv_interp_filter;

  localparam int RL = 4;
  localparam int R  = 1 << RL;
  localparam int DW = 32;

  logic          clk;
  logic          n_rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;

  int     errors;
  int     checks;
  longint sbq[$];
  bit     primed;
  longint xp;
  bit     rand_ready;
  logic   ready_manual;

  mv_interp_filter #(.RATIO_LOG2(RL), .DW(DW)) dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Reference: output k lies on the straight line from x_prev to x_new, scaled by R.
  function automatic longint interp(input longint a, input longint b, input int k);
    longint num;
    num = longint'(R) * a + longint'(k) * (b - a);
`ifdef MV_INTERP_ROUND_EN
    num = num + longint'(R / 2);
`endif
    return fdiv(num, longint'(R));
  endfunction

  task automatic model_accept(input logic [DW-1:0] v);
    longint nv;
    nv = longint'($signed(v));
    if (!primed) begin
      primed = 1'b1;
    end else begin
      for (int k = 0; k < R; k++) sbq.push_back(interp(xp, nv, k));
    end
    xp = nv;
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit acc;
    bit done;
    int cyc;
    done = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    din = v;
    din_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_accept(v);
        din_valid = 1'b0;
        done = 1'b1;
      end else begin
        cyc++;
        if (cyc > 300) begin
          check("send_timeout", 0, 1);
          din_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_dout", longint'(dout), 0);
    check("rst_dout_valid", longint'(dout_valid), 0);
    check("rst_din_ready", longint'(din_ready), 1);
    check("rst_busy", longint'(busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    sbq.delete();
    primed = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", longint'(sbq.size()), 0);
    @(negedge clk);
  endtask

  // Downstream ready: random when enabled, otherwise the value the test sequence asks for.
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_manual;
    end
  end

  // Monitor: flags follow the model's run occupancy; presented dout must match the queue head.
  initial begin
    bit run;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        run = (sbq.size() != 0);
        check("dout_valid", longint'(dout_valid), longint'(run));
        check("busy", longint'(busy), longint'(run));
        check("din_ready", longint'(din_ready), longint'(!run));
        if (dout_valid && run) begin
          check("dout", longint'($signed(dout)), sbq[0]);
          if (dout_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    bit hit;
    logic [DW-1:0] v;
    errors = 0;
    checks = 0;
    primed = 1'b0;
    xp = 0;
    rand_ready = 1'b0;
    ready_manual = 1'b1;
    n_rst = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    n_rst = 1'b1;

    // Ramp 0 -> 160.
    send(32'd0);
    send(32'd160);
    drain();

    // Small negative step exercises floor versus rounding.
    do_reset();
    send(32'd0);
    send(32'hFFFF_FFFF);
    drain();

    // Stall the output while 30 is presented.
    do_reset();
    send(32'd0);
    send(32'd160);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (dout_valid && dout == 32'd30) hit = 1'b1;
    end
    check("stall_reach_30", longint'(hit), 1);
    ready_manual = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_hold_30", longint'(dout), 30);
    ready_manual = 1'b1;
    drain();

    // Full-scale swing from max positive to min negative.
    do_reset();
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    drain();

    // Reset in the middle of a run, then re-prime.
    do_reset();
    send(32'd0);
    send(32'd160);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == R - 7) hit = 1'b1;
    end
    check("midrun_reach_k7", longint'(hit), 1);
    check("midrun_dout_k7", longint'(dout), 70);
    n_rst = 1'b0;
    sbq.delete();
    primed = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    n_rst = 1'b1;
    send(32'd100);
    send(32'd116);
    drain();

    // Next sample offered while the run is still in progress.
    do_reset();
    send(32'd0);
    send(32'd160);
    send(32'd50);
    drain();

    // Random samples with random downstream stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (n % 2 == 0) v = $urandom_range(0, 2000) - 32'd1000;
      else            v = $urandom;
      send(v);
    end
    drain();
    rand_ready = 1'b0;
    ready_manual = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
